// File: rtl/uart_tx_fifo.sv
// Transmit byte queue feeding uart_top: buffers host writes and launches one
// frame at a time, flagging FIFO overflow and missing busy acknowledges.
module uart_tx_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     ack_timeout,
  input  logic                     clr_err,
  output logic                     tx_start,
  output logic [DATA_WIDTH-1:0]    tx_data_in,
  input  logic                     tx_busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [DATA_WIDTH-1:0]   mem_r [DEPTH];
  logic [PW-1:0]           wr_ptr_r;
  logic [PW-1:0]           rd_ptr_r;
  logic [TW-1:0]           tmo_cnt_r;
  logic [TW-1:0]           tmo_cnt_nxt_s;
  logic [CW-1:0]           count_nxt_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    tx_start_nxt_s;
  logic                    tmo_set_s;
  logic                    ovf_set_s;

  // Launch FSM next-state decode plus push/pop/occupancy bookkeeping.
  always_comb begin
    state_nxt_s    = state_r;
    tmo_cnt_nxt_s  = tmo_cnt_r;
    pop_s          = 1'b0;
    tx_start_nxt_s = 1'b0;
    tmo_set_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty && !tx_busy) begin
          pop_s          = 1'b1;
          tx_start_nxt_s = 1'b1;
          state_nxt_s    = START;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        tmo_cnt_nxt_s = {TW{1'b0}};
        state_nxt_s   = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt_s = WAIT_DONE;
        end else if (tmo_cnt_r == TW'(ACK_TIMEOUT - 1)) begin
          // The UART never acknowledged; the popped byte is abandoned.
          tmo_set_s   = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          tmo_cnt_nxt_s = tmo_cnt_r + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase

    push_s    = wr_en && !full;
    ovf_set_s = wr_en && full;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count + CW'(1);
      2'b01:   count_nxt_s = count - CW'(1);
      default: count_nxt_s = count;
    endcase
  end

  // Control state, pointers, occupancy, launch outputs and sticky flags.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r     <= IDLE;
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      tmo_cnt_r   <= {TW{1'b0}};
      count       <= {CW{1'b0}};
      full        <= 1'b0;
      empty       <= 1'b1;
      tx_start    <= 1'b0;
      tx_data_in  <= {DATA_WIDTH{1'b0}};
      overflow    <= 1'b0;
      ack_timeout <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      tmo_cnt_r <= tmo_cnt_nxt_s;
      tx_start  <= tx_start_nxt_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r   <= rd_ptr_r + PW'(1);
        tx_data_in <= mem_r[rd_ptr_r];
      end
      count <= count_nxt_s;
      full  <= (count_nxt_s == CW'(DEPTH));
      empty <= (count_nxt_s == {CW{1'b0}});
      // A set event in the same cycle as clr_err keeps the flag high.
      if (ovf_set_s) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (tmo_set_s) begin
        ack_timeout <= 1'b1;
      end else if (clr_err) begin
        ack_timeout <= 1'b0;
      end
    end
  end

  // FIFO storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo with a small behavioural UART busy model.
module tb_uart_tx_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int A     = 16;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic                  wr_en = 1'b0;
  logic [DW-1:0]         wr_data = '0;
  logic                  clr_err = 1'b0;
  logic                  full, empty, overflow, ack_timeout, tx_start;
  logic [$clog2(DEPTH):0] count;
  logic [DW-1:0]         tx_data_in;
  logic                  busy_model = 1'b0;
  logic                  busy_force = 1'b0;
  logic                  tx_busy;
  logic                  model_silent = 1'b0;
  logic                  model_active = 1'b0;
  int                    busy_delay = 2;
  int                    busy_len = 100;
  int                    total = 0;
  int                    bad = 0;
  int                    launches = 0;
  logic [DW-1:0]         exp_q [$];

  assign tx_busy = busy_model | busy_force;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ACK_TIMEOUT(A)) dut (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .ack_timeout(ack_timeout), .clr_err(clr_err), .tx_start(tx_start),
    .tx_data_in(tx_data_in), .tx_busy(tx_busy)
  );

  // UART model: raises busy busy_delay cycles after a launch, holds busy_len.
  initial begin : uart_model
    forever begin
      @(negedge clk);
      if (tx_start && !model_silent) begin
        model_active = 1'b1;
        repeat (busy_delay) @(negedge clk);
        busy_model = 1'b1;
        repeat (busy_len) @(negedge clk);
        busy_model = 1'b0;
        model_active = 1'b0;
      end
    end
  end

  // Monitor: every launch pops the scoreboard and checks the presented byte.
  initial begin : monitor
    logic          prev_start;
    logic [DW-1:0] exp_b;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        launches++;
        total++;
        if (prev_start) begin
          bad++;
          $display("FAIL start_pulse: tx_start high two cycles running, got 1 want 0");
        end
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL launch_unexpected: got tx_data_in=%h, want no launch", tx_data_in);
        end else begin
          exp_b = exp_q.pop_front();
          if (tx_data_in !== exp_b) begin
            bad++;
            $display("FAIL launch_data: got %h want %h", tx_data_in, exp_b);
          end
        end
      end
      prev_start = tx_start;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push1(input logic [DW-1:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    exp_q.push_back(b);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic drain(input int max_cyc, input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || model_active || tx_busy || !empty) && n < max_cyc) begin
      @(negedge clk);
      #1;
      n++;
    end
    repeat (6) @(negedge clk);
    check({nm, "_left"}, exp_q.size(), 0);
    check({nm, "_count"}, count, 0);
    check({nm, "_empty"}, empty, 1);
  endtask

  task automatic wait_busy(input int max_cyc, input string nm);
    int n;
    n = 0;
    while (!busy_model && n < max_cyc) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(nm, busy_model, 1);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int l0;
    repeat (2) @(negedge clk);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_start", tx_start, 0);
    check("rst_data", tx_data_in, 0);
    check("rst_ovf", overflow, 0);
    check("rst_tmo", ack_timeout, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Single byte with first-byte latency
    busy_delay = 2;
    busy_len   = 100;
    push1(8'hA5);
    check("t1_count1", count, 1);
    check("t1_nempty", empty, 0);
    check("t1_nostart", tx_start, 0);
    @(negedge clk);
    check("t1_start", tx_start, 1);
    check("t1_count0", count, 0);
    @(negedge clk);
    check("t1_start_low", tx_start, 0);
    wait_busy(20, "t1_busy_rise");
    check("t1_hold_a", tx_data_in, 8'hA5);
    repeat (50) @(negedge clk);
    check("t1_hold_b", tx_data_in, 8'hA5);
    drain(300, "t1");

    // Fill and overflow with the UART held busy
    busy_force = 1'b1;
    busy_delay = 1;
    busy_len   = 3;
    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(i);
      if (i < 16) exp_q.push_back(8'(i));
      if (i == 16) begin
        check("t2_full", full, 1);
        check("t2_count16", count, 16);
        check("t2_no_ovf_yet", overflow, 0);
      end
      @(negedge clk);
    end
    wr_en = 1'b0;
    check("t2_ovf", overflow, 1);
    check("t2_count_stay", count, 16);
    busy_force = 1'b0;
    drain(400, "t2");
    check("t2_ovf_sticky", overflow, 1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("t2_ovf_clr", overflow, 0);

    // Streaming across pointer wrap
    busy_delay = 1;
    busy_len   = 2;
    for (int i = 0; i < 40; i++) begin
      push1(8'h40 + 8'(i));
      repeat ((i % 2 == 1) ? 4 : 2) @(negedge clk);
    end
    drain(500, "t3");
    check("t3_no_ovf", overflow, 0);

    // Acknowledge timeout, recovery and clear
    model_silent = 1'b1;
    push1(8'h3C);
    repeat (A + 1) @(negedge clk);
    check("t4_tmo_early", ack_timeout, 0);
    @(negedge clk);
    check("t4_tmo_set", ack_timeout, 1);
    model_silent = 1'b0;
    push1(8'h3D);
    drain(100, "t4");
    check("t4_tmo_sticky", ack_timeout, 1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("t4_tmo_clr", ack_timeout, 0);
    model_silent = 1'b1;
    push1(8'h3E);
    repeat (A + 1) @(negedge clk);
    clr_err = 1'b1;
    check("t4_pre_coinc", ack_timeout, 0);
    @(negedge clk);
    clr_err = 1'b0;
    check("t4_set_wins", ack_timeout, 1);
    @(negedge clk);
    check("t4_set_holds", ack_timeout, 1);
    model_silent = 1'b0;

    // Simultaneous push and pop
    busy_force = 1'b1;
    busy_delay = 1;
    busy_len   = 2;
    push1(8'h50);
    push1(8'h51);
    push1(8'h52);
    check("t5_count3", count, 3);
    wr_en   = 1'b1;
    wr_data = 8'h53;
    exp_q.push_back(8'h53);
    busy_force = 1'b0;
    @(negedge clk);
    wr_en = 1'b0;
    check("t5_start", tx_start, 1);
    check("t5_count_stay", count, 3);
    drain(200, "t5");

    // Reset while a frame is in flight
    busy_force = 1'b1;
    busy_len   = 60;
    for (int i = 0; i < 17; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'h80 + 8'(i);
      if (i < 16) exp_q.push_back(8'h80 + 8'(i));
      @(negedge clk);
    end
    wr_en = 1'b0;
    busy_force = 1'b0;
    wait_busy(20, "t6_busy_rise");
    repeat (3) @(negedge clk);
    check("t6_count15", count, 15);
    check("t6_ovf_pre", overflow, 1);
    check("t6_tmo_pre", ack_timeout, 1);
    rstn = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    check("t6_count", count, 0);
    check("t6_empty", empty, 1);
    check("t6_full", full, 0);
    check("t6_start", tx_start, 0);
    check("t6_data", tx_data_in, 0);
    check("t6_ovf", overflow, 0);
    check("t6_tmo", ack_timeout, 0);
    l0 = launches;
    repeat (70) @(negedge clk);
    check("t6_no_launch", launches, l0);
    busy_len = 3;
    push1(8'h70);
    drain(100, "t6");
    check("t6_relaunch", launches, l0 + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
